// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and gain helper for the vectoring CORDIC.
// CORDIC_GAIN_COMP_EN selects the 1/K magnitude correction in the top.
package cordic_pkg;

  localparam int XY_W = 19;
  localparam int Z_W  = 18;

  localparam logic [Z_W-1:0] HALF_PI  = 18'd65536;
  localparam logic [15:0]    INV_GAIN = 16'd19898;

  // round(atan(2^-i) * 2^17 / pi)
  localparam logic [Z_W-1:0] ATAN [16] = '{
    18'd32768, 18'd19344, 18'd10221, 18'd5188,
    18'd2604,  18'd1303,  18'd652,   18'd326,
    18'd163,   18'd81,    18'd41,    18'd20,
    18'd10,    18'd5,     18'd3,     18'd1
  };

  typedef enum logic [1:0] {
    IDLE,
    ITERATE,
    GAIN,
    DONE
  } state_t;

  function automatic logic signed [XY_W-1:0] gain_comp(
    input logic signed [XY_W-1:0] x
  );
    logic signed [XY_W+15:0] acc;
    acc = '0;
    for (int k = 0; k < 16; k++) begin
      if (INV_GAIN[k]) acc += (XY_W+16)'(x) <<< k;
    end
    return XY_W'(acc >>> 15);
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational vectoring micro-rotation; direction follows sign of y.
module cordic_vec_step
  import cordic_pkg::*;
(
  input  logic signed [XY_W-1:0] x,
  input  logic signed [XY_W-1:0] y,
  input  logic        [Z_W-1:0]  z,
  input  logic        [3:0]      i,
  input  logic        [Z_W-1:0]  atan,
  output logic signed [XY_W-1:0] x_next,
  output logic signed [XY_W-1:0] y_next,
  output logic        [Z_W-1:0]  z_next
);

  logic signed [XY_W-1:0] xs;
  logic signed [XY_W-1:0] ys;

  assign xs = x >>> i;
  assign ys = y >>> i;

  always_comb begin
    x_next = x + ys;
    y_next = y - xs;
    z_next = z + atan;
    if (y[XY_W-1]) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - atan;
    end
  end

endmodule

// File: rtl/cordic_vec_iter.sv
// Iterative vectoring CORDIC: (x, y) -> (magnitude, phase), one step per clock.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales mag_out by 1/K.
module cordic_vec_iter
  import cordic_pkg::*;
#(
  parameter int ITER = 16,
  parameter int IN_W = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] x_in,
  input  logic signed [IN_W-1:0] y_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [XY_W-1:0] mag_out,
  output logic signed [Z_W-1:0]  phase_out
);

  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t                 state;
  logic signed [XY_W-1:0] x_q;
  logic signed [XY_W-1:0] y_q;
  logic        [Z_W-1:0]  z_q;
  logic        [3:0]      i_q;
  logic                   zero_q;

  logic signed [XY_W-1:0] x_n;
  logic signed [XY_W-1:0] y_n;
  logic        [Z_W-1:0]  z_n;
  logic signed [XY_W-1:0] xe;
  logic signed [XY_W-1:0] ye;

  assign xe = {{(XY_W-IN_W){x_in[IN_W-1]}}, x_in};
  assign ye = {{(XY_W-IN_W){y_in[IN_W-1]}}, y_in};

  cordic_vec_step u_step (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .i      (i_q),
    .atan   (ATAN[i_q]),
    .x_next (x_n),
    .y_next (y_n),
    .z_next (z_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag_out   <= '0;
      phase_out <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      i_q       <= '0;
      zero_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            zero_q   <= (xe == '0) && (ye == '0);
            i_q      <= '0;
            in_ready <= 1'b0;
            state    <= ITERATE;
            // fold the left half-plane into the convergence range
            if (!xe[XY_W-1]) begin
              x_q <= xe;
              y_q <= ye;
              z_q <= '0;
            end else if (!ye[XY_W-1]) begin
              x_q <= ye;
              y_q <= -xe;
              z_q <= HALF_PI;
            end else begin
              x_q <= -ye;
              y_q <= xe;
              z_q <= -HALF_PI;
            end
          end
        end
        ITERATE: begin
          x_q <= x_n;
          y_q <= y_n;
          z_q <= z_n;
          i_q <= i_q + 4'd1;
          if (i_q == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= GAIN;
`else
            state     <= DONE;
            out_valid <= 1'b1;
            mag_out   <= x_n;
            phase_out <= zero_q ? '0 : z_n;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
          mag_out   <= gain_comp(x_q);
          phase_out <= zero_q ? '0 : z_q;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vec_iter.sv
// Directed scoreboard bench for cordic_vec_iter using a real-valued polar model.
module tb_cordic_vec_iter;

  localparam real PI = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT   = 17;
  localparam real KG    = 1.0;
  localparam int  TOL_M = 4;
`else
  localparam int  LAT   = 16;
  localparam real KG    = 1.6467602581;
  localparam int  TOL_M = 8;
`endif
  localparam int TOL_P = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [16:0] x_in = '0;
  logic signed [16:0] y_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [18:0] mag_out;
  logic signed [17:0] phase_out;

  typedef struct {
    int ph;
    int mag;
    int tp;
    int tm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   t_acc = 0;

  cordic_vec_iter #(.ITER(16), .IN_W(17)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .phase_out (phase_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int act, int exp, int tol);
    int d;
    d = act - exp;
    n_vec++;
    assert (((d <= tol) && (d >= -tol)) === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d tol %0d",
             tag, act, exp, tol);
    end
  endtask

  task automatic chk_ph(string tag, int act, int exp, int tol);
    int d;
    d = act - exp;
    if (d > 131072) d -= 262144;
    if (d < -131072) d += 262144;
    n_vec++;
    assert (((d <= tol) && (d >= -tol)) === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d tol %0d",
             tag, act, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int x, int y);
    exp_t e;
    real  r;
    int   n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1, 0);
    in_valid = 1'b1;
    x_in = 17'(x);
    y_in = 17'(y);
    tick();
    in_valid = 1'b0;
    t_acc = cyc;
    r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    e.mag = int'(r * KG);
    e.ph  = int'($atan2(real'(y), real'(x)) * 131072.0 / PI);
    e.tp  = (x == 0 && y == 0) ? 0 : TOL_P;
    e.tm  = (x == 0 && y == 0) ? 0 : TOL_M;
    sb.push_back(e);
  endtask

  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    ok = (n < 200);
    if (!ok) chk("out_timeout", 0, 1, 0);
  endtask

  task automatic check_res(exp_t e);
    chk_ph("phase", int'(phase_out), e.ph, e.tp);
    chk("mag", int'(mag_out), e.mag, e.tm);
  endtask

  task automatic recv();
    bit   ok;
    exp_t e;
    wait_out(ok);
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      chk("latency", cyc - t_acc, LAT, 0);
      check_res(e);
      tick();
      chk("hs_out_valid", int'(out_valid), 0, 0);
      chk("hs_in_ready", int'(in_ready), 1, 0);
    end
  endtask

  initial begin
    bit   ok;
    exp_t e;
    int   rx, ry;

    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_mag", int'(mag_out), 0, 0);
    chk("rst_phase", int'(phase_out), 0, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_out_valid", int'(out_valid), 0, 0);

    send(16384, 0);            recv();
    send(0, 16384);            recv();
    send(16384, -16384);       recv();
    send(-16384, 16384);       recv();
    send(-16384, -16384);      recv();
    send(0, 0);                recv();
    send(-65536, -65536);      recv();
    send(65535, 65535);        recv();
    for (int k = 0; k < 4; k++) begin
      rx = int'($urandom_range(57343)) + 8192;
      ry = int'($urandom_range(57343)) + 8192;
      if ($urandom_range(1) == 1) rx = -rx;
      if ($urandom_range(1) == 1) ry = -ry;
      send(rx, ry);
      recv();
    end

    // backpressure: result held, new input ignored
    out_ready = 1'b0;
    send(16384, -16384);
    wait_out(ok);
    if (ok) begin
      e = sb.pop_front();
      chk("bp_latency", cyc - t_acc, LAT, 0);
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1;
        x_in = 17'sd1000;
        y_in = 17'sd2000;
        tick();
        chk("bp_out_valid", int'(out_valid), 1, 0);
        chk("bp_in_ready", int'(in_ready), 0, 0);
        check_res(e);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", int'(out_valid), 0, 0);
      chk("bp_release_ready", int'(in_ready), 1, 0);
      for (int k = 0; k < LAT + 3; k++) tick();
      chk("bp_no_ghost", int'(out_valid), 0, 0);
    end

    // reset mid-iteration discards the pending result
    send(16384, 16384);
    for (int k = 0; k < 7; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0, 0);
    chk("mid_rst_mag", int'(mag_out), 0, 0);
    chk("mid_rst_phase", int'(phase_out), 0, 0);
    sb.delete();
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", int'(in_ready), 1, 0);
    send(16384, 0);
    recv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
